// File: rtl/bike_bram_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bike_bram_pkg
// Description : Shared types and helpers for the BIKE true-dual-port RAM.
//               Provides the clear-engine state type, the WRITE_MODE
//               encodings and the byte-lane merge function.
// Revision    : 1.0 - initial release
// ============================================================================
package bike_bram_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int WM_READ_FIRST  = 0;
    localparam int WM_WRITE_FIRST = 1;

    // Widest word merge_bytes can handle. Callers zero-extend their operands
    // to this width and truncate the result back to their own word size.
    localparam int c_MERGE_MAX_DW = 256;
    localparam int c_MERGE_MAX_NB = 256;

    // Replace every byte lane of old_w whose enable bit is set with the
    // matching lane of new_w. bw is the lane width in bits.
    function automatic logic [c_MERGE_MAX_DW-1:0] merge_bytes(
        input logic [c_MERGE_MAX_DW-1:0] old_w,
        input logic [c_MERGE_MAX_DW-1:0] new_w,
        input logic [c_MERGE_MAX_NB-1:0] we,
        input int                        bw
    );
        logic [c_MERGE_MAX_DW-1:0] res;
        int                        lane;
        int                        bit_in_lane;
        res         = old_w;
        lane        = 0;
        bit_in_lane = 0;
        for (int i = 0; i < c_MERGE_MAX_DW; i++) begin
            if (we[lane[7:0]]) begin
                res[i[7:0]] = new_w[i[7:0]];
            end
            bit_in_lane++;
            if (bit_in_lane == bw) begin
                bit_in_lane = 0;
                lane++;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bike_bram_clr_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bike_bram_clr_fsm
// Description : Clear engine for the BIKE dual-port RAM. After reset, or on a
//               clr_start pulse while idle, it sweeps every word address from
//               0 up to 2**ADDR_WIDTH-1, one per cycle, and requests a zero
//               write on each. While sweeping it reports busy.
// Ports       : clk         - clock, rising edge
//               rst         - asynchronous active-high reset (restarts sweep)
//               i_clr_start - request a full clear (ignored while busy)
//               o_busy      - engine owns the array
//               o_clr_we    - zero-write request for the current address
//               o_clr_addr  - address being cleared
// Revision    : 1.0 - initial release
// ============================================================================
module bike_bram_clr_fsm
    import bike_bram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_clr_start,
    output logic                  o_busy,
    output logic                  o_clr_we,
    output logic [ADDR_WIDTH-1:0] o_clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] c_CNT_LAST = '1;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;

    // State register: reset lands in CLEAR so the array is swept on start-up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Sweep counter is held at zero in IDLE so a new clear starts at word 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_clr_start)          w_state_nxt = CLEAR;
            CLEAR:   if (r_cnt == c_CNT_LAST)  w_state_nxt = IDLE;
            default:                           w_state_nxt = CLEAR;
        endcase
    end

    always_comb begin
        o_busy     = (r_state == CLEAR);
        o_clr_we   = (r_state == CLEAR);
        o_clr_addr = r_cnt;
    end

endmodule
`default_nettype wire

// File: rtl/bike_bram_tdp_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : bike_bram_tdp_param
// Description : Parametrised true-dual-port RAM with byte write enables,
//               read-first / write-first read data, same-address collision
//               flagging and a built-in clear engine. Port A wins every byte
//               lane that both ports write to the same word in one cycle; a
//               port reading a word the other port writes sees the old word.
// Ports       : clk, rst               - clock / async active-high reset
//               i_clr_start, o_busy    - clear request / clear in progress
//               i_en_x, i_we_x         - port enable, byte write enables
//               i_addr_x, i_din_x      - word address, write data
//               o_dout_x, o_vld_x      - read data and its valid flag
//               o_collision            - same-address conflict pulse
// Options     : BIKE_BRAM_OUTREG_EN - adds an output register stage on
//               dout/vld/collision (read latency 2 instead of 1).
// Revision    : 1.0 - initial release
// ============================================================================
module bike_bram_tdp_param
    import bike_bram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int WRITE_MODE = WM_READ_FIRST
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_clr_start,
    output logic                             o_busy,
    input  logic                             i_en_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_we_a,
    input  logic [ADDR_WIDTH-1:0]            i_addr_a,
    input  logic [DATA_WIDTH-1:0]            i_din_a,
    output logic [DATA_WIDTH-1:0]            o_dout_a,
    output logic                             o_vld_a,
    input  logic                             i_en_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] i_we_b,
    input  logic [ADDR_WIDTH-1:0]            i_addr_b,
    input  logic [DATA_WIDTH-1:0]            i_din_b,
    output logic [DATA_WIDTH-1:0]            o_dout_b,
    output logic                             o_vld_b,
    output logic                             o_collision
);

    localparam int NB    = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_w,
        input logic [DATA_WIDTH-1:0] new_w,
        input logic [NB-1:0]         we
    );
        return DATA_WIDTH'(merge_bytes(c_MERGE_MAX_DW'(old_w),
                                       c_MERGE_MAX_DW'(new_w),
                                       c_MERGE_MAX_NB'(we),
                                       BYTE_WIDTH));
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_busy;
    logic                  w_clr_we;
    logic [ADDR_WIDTH-1:0] w_clr_addr;

    bike_bram_clr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_fsm (
        .clk         (clk),
        .rst         (rst),
        .i_clr_start (i_clr_start),
        .o_busy      (w_busy),
        .o_clr_we    (w_clr_we),
        .o_clr_addr  (w_clr_addr)
    );

    assign o_busy = w_busy;

    logic                  w_acc_a, w_acc_b;
    logic                  w_wr_a, w_wr_b;
    logic                  w_same_addr, w_wr_wr;
    logic                  w_coll;
    logic [DATA_WIDTH-1:0] w_rd_a, w_rd_b;
    logic [DATA_WIDTH-1:0] w_own_a, w_own_b;
    logic [DATA_WIDTH-1:0] w_new_a;
    logic [DATA_WIDTH-1:0] w_rdata_a, w_rdata_b;
    logic                  w_pa_we;
    logic [ADDR_WIDTH-1:0] w_pa_addr;
    logic [DATA_WIDTH-1:0] w_pa_data;

    // User accesses are accepted only when the clear engine is idle.
    assign w_acc_a     = i_en_a & ~w_busy;
    assign w_acc_b     = i_en_b & ~w_busy;
    assign w_wr_a      = w_acc_a & (|i_we_a);
    assign w_wr_b      = w_acc_b & (|i_we_b);
    assign w_same_addr = (i_addr_a == i_addr_b);
    assign w_wr_wr     = w_wr_a & w_wr_b & w_same_addr;
    assign w_coll      = w_acc_a & w_acc_b & w_same_addr & (w_wr_a | w_wr_b);

    assign w_rd_a  = r_mem[i_addr_a];
    assign w_rd_b  = r_mem[i_addr_b];
    assign w_own_a = f_merge(w_rd_a, i_din_a, i_we_a);
    assign w_own_b = f_merge(w_rd_b, i_din_b, i_we_b);
    // On a write/write hit, A's lanes are laid over B's merged word so that
    // A wins shared lanes and B still supplies lanes only it enables.
    assign w_new_a = f_merge(w_wr_wr ? w_own_b : w_rd_a, i_din_a, i_we_a);

    // Write-first returns only this port's own merge; the other port's write
    // in the same cycle is never visible to it.
    assign w_rdata_a = (WRITE_MODE == WM_WRITE_FIRST && w_wr_a) ? w_own_a : w_rd_a;
    assign w_rdata_b = (WRITE_MODE == WM_WRITE_FIRST && w_wr_b) ? w_own_b : w_rd_b;

    // Clear engine borrows port A's write path.
    assign w_pa_we   = w_clr_we | w_wr_a;
    assign w_pa_addr = w_clr_we ? w_clr_addr : i_addr_a;
    assign w_pa_data = w_clr_we ? '0 : w_new_a;

    // Port A's write comes last so it overrides B on a shared address.
    always_ff @(posedge clk) begin
        if (w_wr_b) begin
            r_mem[i_addr_b] <= w_own_b;
        end
        if (w_pa_we) begin
            r_mem[w_pa_addr] <= w_pa_data;
        end
    end

    logic [DATA_WIDTH-1:0] r_dout_a, r_dout_b;
    logic                  r_vld_a, r_vld_b, r_coll;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_a <= '0;
            r_dout_b <= '0;
            r_vld_a  <= 1'b0;
            r_vld_b  <= 1'b0;
            r_coll   <= 1'b0;
        end else begin
            r_dout_a <= w_acc_a ? w_rdata_a : '0;
            r_dout_b <= w_acc_b ? w_rdata_b : '0;
            r_vld_a  <= w_acc_a;
            r_vld_b  <= w_acc_b;
            r_coll   <= w_coll;
        end
    end

`ifdef BIKE_BRAM_OUTREG_EN
    logic [DATA_WIDTH-1:0] r_dout_a_q, r_dout_b_q;
    logic                  r_vld_a_q, r_vld_b_q, r_coll_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_a_q <= '0;
            r_dout_b_q <= '0;
            r_vld_a_q  <= 1'b0;
            r_vld_b_q  <= 1'b0;
            r_coll_q   <= 1'b0;
        end else begin
            r_dout_a_q <= r_dout_a;
            r_dout_b_q <= r_dout_b;
            r_vld_a_q  <= r_vld_a;
            r_vld_b_q  <= r_vld_b;
            r_coll_q   <= r_coll;
        end
    end

    assign o_dout_a    = r_dout_a_q;
    assign o_dout_b    = r_dout_b_q;
    assign o_vld_a     = r_vld_a_q;
    assign o_vld_b     = r_vld_b_q;
    assign o_collision = r_coll_q;
`else
    assign o_dout_a    = r_dout_a;
    assign o_dout_b    = r_dout_b;
    assign o_vld_a     = r_vld_a;
    assign o_vld_b     = r_vld_b;
    assign o_collision = r_coll;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bike_bram_tdp_param.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_bike_bram_tdp_param
// Description : Self-checking bench for bike_bram_tdp_param. Two instances
//               (read-first and write-first) share all inputs; a word-array
//               reference model predicts data, valid, collision and busy.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bike_bram_tdp_param;

    localparam int DEPTH = 1024;
`ifdef BIKE_BRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        clr_start;
    logic        en_a, en_b;
    logic [3:0]  we_a, we_b;
    logic [9:0]  addr_a, addr_b;
    logic [31:0] din_a, din_b;

    logic        busy0, vld_a0, vld_b0, coll0;
    logic        busy1, vld_a1, vld_b1, coll1;
    logic [31:0] dout_a0, dout_b0, dout_a1, dout_b1;

    always #5 clk = ~clk;

    bike_bram_tdp_param #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .WRITE_MODE(0)) u_dut0 (
        .clk(clk), .rst(rst), .i_clr_start(clr_start), .o_busy(busy0),
        .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a),
        .o_dout_a(dout_a0), .o_vld_a(vld_a0),
        .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b),
        .o_dout_b(dout_b0), .o_vld_b(vld_b0), .o_collision(coll0)
    );

    bike_bram_tdp_param #(.DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(10), .WRITE_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .i_clr_start(clr_start), .o_busy(busy1),
        .i_en_a(en_a), .i_we_a(we_a), .i_addr_a(addr_a), .i_din_a(din_a),
        .o_dout_a(dout_a1), .o_vld_a(vld_a1),
        .i_en_b(en_b), .i_we_b(we_b), .i_addr_b(addr_b), .i_din_b(din_b),
        .o_dout_b(dout_b1), .o_vld_b(vld_b1), .o_collision(coll1)
    );

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] da0, db0, da1, db1;
        logic        va, vb, col;
    } exp_t;

    logic [31:0] m_mem [0:DEPTH-1];
    int          m_left;        // words the clear sweep still has to zero
    exp_t        e_s1, e_s2;    // expected outputs 1 and 2 edges back
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] we);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (we[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic check_outputs();
        exp_t v;
        v = (LAT == 2) ? e_s2 : e_s1;
        chk("dout_a_m0", dout_a0, v.da0);
        chk("dout_b_m0", dout_b0, v.db0);
        chk("dout_a_m1", dout_a1, v.da1);
        chk("dout_b_m1", dout_b1, v.db1);
        chk("vld_a_m0",  32'(vld_a0), 32'(v.va));
        chk("vld_b_m0",  32'(vld_b0), 32'(v.vb));
        chk("vld_a_m1",  32'(vld_a1), 32'(v.va));
        chk("vld_b_m1",  32'(vld_b1), 32'(v.vb));
        chk("coll_m0",   32'(coll0),  32'(v.col));
        chk("coll_m1",   32'(coll1),  32'(v.col));
        chk("busy_m0",   32'(busy0),  32'(m_left != 0));
        chk("busy_m1",   32'(busy1),  32'(m_left != 0));
    endtask

    // Called with inputs settled (negedge); advances one clock and checks.
    task automatic step();
        exp_t        e;
        logic [31:0] oa, ob;
        logic        wa, wb;
        e = '0;
        if (m_left == 0) begin
            oa = m_mem[addr_a];
            ob = m_mem[addr_b];
            wa = en_a && (we_a != 4'h0);
            wb = en_b && (we_b != 4'h0);
            e.va = en_a;
            e.vb = en_b;
            if (en_a) begin
                e.da0 = oa;
                e.da1 = wa ? bmerge(oa, din_a, we_a) : oa;
            end
            if (en_b) begin
                e.db0 = ob;
                e.db1 = wb ? bmerge(ob, din_b, we_b) : ob;
            end
            e.col = en_a && en_b && (addr_a == addr_b) && (wa || wb);
            if (wb) m_mem[addr_b] = bmerge(m_mem[addr_b], din_b, we_b);
            if (wa) m_mem[addr_a] = bmerge(m_mem[addr_a], din_a, we_a);
            if (clr_start) m_left = DEPTH;
        end else begin
            m_mem[DEPTH - m_left] = 32'h0;
            m_left--;
        end
        @(posedge clk);
        e_s2 = e_s1;
        e_s1 = e;
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        clr_start = 1'b0;
        en_a = 1'b0; en_b = 1'b0;
        we_a = 4'h0; we_b = 4'h0;
        addr_a = '0; addr_b = '0;
        din_a = '0;  din_b = '0;
    endtask

    task automatic rand_inputs(input bit allow_clr);
        en_a   = ($urandom_range(0, 3) != 0);
        en_b   = ($urandom_range(0, 3) != 0);
        we_a   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        we_b   = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
        addr_a = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 15));
        addr_b = ($urandom_range(0, 1) == 0) ? addr_a : 10'($urandom_range(0, 15));
        din_a  = $urandom;
        din_b  = $urandom;
        clr_start = allow_clr && ($urandom_range(0, 7) == 0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        m_left = DEPTH;
        e_s1 = '0;
        e_s2 = '0;
        #1;
        check_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Single read on port A; on return the outputs show that read.
    task automatic read_a(input logic [9:0] a);
        idle_inputs();
        en_a = 1'b1;
        addr_a = a;
        step();
        idle_inputs();
        if (LAT == 2) step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int nb;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        idle_inputs();
        #2;
        do_reset();

        // Power-up sweep.
        for (int i = 0; i < DEPTH; i++) step();
        foreach (addr_a[i]) begin end
        read_a(10'd0);    chk("rd0",    dout_a0, 32'h0); chk("rd0_vld", 32'(vld_a0), 32'd1);
        read_a(10'd511);  chk("rd511",  dout_a0, 32'h0);
        read_a(10'd1023); chk("rd1023", dout_a0, 32'h0); chk("rd1023_vld", 32'(vld_a0), 32'd1);

        // Byte-enable merge and read-first / write-first data.
        idle_inputs();
        en_a = 1'b1; we_a = 4'hF;    addr_a = 10'h005; din_a = 32'hDEADBEEF; step();
        we_a = 4'b0101;              din_a = 32'h11223344;                   step();
        idle_inputs();
        if (LAT == 2) step();
        chk("wm0_dout", dout_a0, 32'hDEADBEEF);
        chk("wm1_dout", dout_a1, 32'hDE22BE44);
        read_a(10'h005);
        chk("merge_m0", dout_a0, 32'hDE22BE44);
        chk("merge_m1", dout_a1, 32'hDE22BE44);

        // Write/write collision.
        idle_inputs();
        en_a = 1'b1; we_a = 4'b0011; addr_a = 10'h010; din_a = 32'hAAAAAAAA;
        en_b = 1'b1; we_b = 4'b0110; addr_b = 10'h010; din_b = 32'hBBBBBBBB;
        step();
        idle_inputs();
        if (LAT == 2) step();
        chk("ww_coll", 32'(coll0), 32'd1);
        read_a(10'h010);
        chk("ww_data", dout_a0, 32'h00BBAAAA);

        // Cross-port read while the other port writes.
        idle_inputs();
        en_a = 1'b1; we_a = 4'hF; addr_a = 10'h020; din_a = 32'hA5A5A5A5; step();
        idle_inputs();
        en_a = 1'b1; addr_a = 10'h020;
        en_b = 1'b1; we_b = 4'hF; addr_b = 10'h020; din_b = 32'h12345678;
        step();
        idle_inputs();
        if (LAT == 2) step();
        chk("xr_old_m0", dout_a0, 32'hA5A5A5A5);
        chk("xr_old_m1", dout_a1, 32'hA5A5A5A5);
        chk("xr_coll",   32'(coll0), 32'd1);
        read_a(10'h020);
        chk("xr_new", dout_a0, 32'h12345678);

        // Read latency and zero-when-idle.
        idle_inputs();
        en_a = 1'b1; we_a = 4'hF; addr_a = 10'h030; din_a = 32'hCAFEF00D; step();
        idle_inputs(); step();
        en_a = 1'b1; addr_a = 10'h030; step();
        idle_inputs();
        chk("lat_vld", 32'(vld_a0), 32'(LAT == 1));
        if (LAT == 2) step();
        chk("lat_data", dout_a0, 32'hCAFEF00D);
        repeat (LAT) step();
        chk("idle_dout", dout_a0, 32'h0);
        chk("idle_vld",  32'(vld_a0), 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            rand_inputs(1'b0);
            step();
        end

        // Clear mid-traffic, reset at sweep count 300, full sweep again.
        rand_inputs(1'b0);
        clr_start = 1'b1;
        step();
        for (int i = 0; i < 300; i++) begin
            rand_inputs(1'b1);
            step();
        end
        rand_inputs(1'b1);
        do_reset();
        nb = 0;
        for (int i = 0; i < DEPTH + 8; i++) begin
            if (m_left > 0) rand_inputs(1'b1);
            else idle_inputs();
            if (busy0) nb++;
            step();
        end
        chk("busy_len", 32'(nb), 32'(DEPTH));

        // Every word reads back as zero.
        for (int i = 0; i < DEPTH / 2; i++) begin
            idle_inputs();
            en_a = 1'b1; addr_a = 10'(i);
            en_b = 1'b1; addr_b = 10'(i + DEPTH / 2);
            step();
        end
        read_a(10'h005); chk("clr_rd5",  dout_a0, 32'h0);
        read_a(10'h010); chk("clr_rd10", dout_a0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
